bin2bcd_seq: RTL and testbench



---
 rtl/bin2bcd_pkg.sv | 11 +
 rtl/bin2bcd_if.sv | 17 +
 rtl/bin2bcd_seq_bcd_adj3.sv | 9 +
 rtl/bin2bcd_seq.sv | 112 +++++++++++
 tb/tb_bin2bcd_seq.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared encodings and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          DIGIT_W    = 4;
  localparam logic [3:0]  BLANK_CODE = 4'b1111;
endpackage

// File: rtl/bin2bcd_if.sv
// Request/result bundle between the datapath (master) and the converter (slave).
interface bin2bcd_if
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                      start;
  logic [WIDTH-1:0]          bin;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] bcd;
  logic                      overflow;

  modport master (output start, bin, input busy, done, bcd, overflow);
  modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin2bcd_seq_bcd_adj3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_adj3
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] in_i,
  output logic [DIGIT_W-1:0] out_o
);
  assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, with optional
// leading-zero blanking for the seven-segment decoders downstream.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int DIGITS        = 5,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clock,
  input  logic       resetn,
  bin2bcd_if.slave   bus
);
  localparam int BW    = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BCD_RST = (BLANK_LEADING != 0) ? {DIGITS{BLANK_CODE}} : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    scr_q, scr_d, adj;
  logic             ovf_int_q, ovf_int_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  // Zero digits above the most significant nonzero digit show as blank; digit 0 always shows.
  function automatic logic [BW-1:0] blank_lead(input logic [BW-1:0] v);
    logic lead;
    lead       = 1'b1;
    blank_lead = v;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (v[DIGIT_W*i +: DIGIT_W] == '0))
        blank_lead[DIGIT_W*i +: DIGIT_W] = BLANK_CODE;
      else
        lead = 1'b0;
    end
  endfunction

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .in_i  (scr_q[DIGIT_W*g +: DIGIT_W]),
      .out_o (adj[DIGIT_W*g +: DIGIT_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    scr_d     = scr_q;
    ovf_int_d = ovf_int_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = CONV;
          shreg_d   = bus.bin;
          scr_d     = '0;
          cnt_d     = '0;
          ovf_int_d = 1'b0;
        end
      end
      CONV: begin
        // Adjusted scratch and shift register move left together; the top BCD bit falls out.
        scr_d     = {adj[BW-2:0], shreg_q[WIDTH-1]};
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        ovf_int_d = ovf_int_q | adj[BW-1];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1))
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        ovf_d   = ovf_int_q;
        bcd_d   = ((BLANK_LEADING != 0) && !ovf_int_q) ? blank_lead(scr_q) : scr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ovf_int_q <= 1'b0;
      bcd_q     <= BCD_RST;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_int_q <= ovf_int_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clock) begin
    shreg_q <= shreg_d;
    scr_q   <= scr_d;
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: default, unblanked and 4-digit builds side by side.
module tb_bin2bcd_seq;
  logic        clk = 1'b0;
  logic        resetn;
  logic        start_tb;
  logic [15:0] bin_tb;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  bin2bcd_if #(.WIDTH(16), .DIGITS(5)) if5 ();
  bin2bcd_if #(.WIDTH(16), .DIGITS(5)) ifnb ();
  bin2bcd_if #(.WIDTH(16), .DIGITS(4)) if4 ();

  assign if5.start  = start_tb;  assign if5.bin  = bin_tb;
  assign ifnb.start = start_tb;  assign ifnb.bin = bin_tb;
  assign if4.start  = start_tb;  assign if4.bin  = bin_tb;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LEADING(1)) dut (
    .clock(clk), .resetn(resetn), .bus(if5));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .BLANK_LEADING(0)) dut_nb (
    .clock(clk), .resetn(resetn), .bus(ifnb));
  bin2bcd_seq #(.WIDTH(16), .DIGITS(4), .BLANK_LEADING(1)) dut4 (
    .clock(clk), .resetn(resetn), .bus(if4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference: digits by repeated division, leading zeros blanked unless overflowed.
  function automatic logic [31:0] exp_bcd(input int unsigned v, input int nd, input bit blank);
    logic [31:0] r;
    int unsigned t, p;
    bit lead;
    r = '0; t = v; p = 1;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
      p = p * 10;
    end
    if (blank && (v < p)) begin
      lead = 1'b1;
      for (int i = nd - 1; i >= 1; i--) begin
        if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
    return r;
  endfunction

  // Pulse start for one accepting edge, then watch 20 edges for busy/done behaviour.
  task automatic conv(input logic [15:0] v, output int lat, output int busyc, output int donec);
    @(negedge clk);
    bin_tb = v; start_tb = 1'b1;
    @(posedge clk);
    #1 start_tb = 1'b0;
    bin_tb = 16'hA5A5;
    lat = -1; busyc = 0; donec = 0;
    if (if5.busy) busyc++;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (if5.done) begin
        donec++;
        if (lat < 0) lat = n;
      end
      if (if5.busy) busyc++;
    end
  endtask

  logic [15:0] vin  [8] = '{16'd65535, 16'd1234, 16'd0, 16'd12345, 16'd7, 16'd10000, 16'd9999, 16'd100};
  logic [19:0] e5   [8] = '{20'h65535, 20'hF1234, 20'hFFFF0, 20'h12345, 20'hFFFF7, 20'h10000, 20'hF9999, 20'hFF100};
  logic [19:0] e5nb [8] = '{20'h65535, 20'h01234, 20'h00000, 20'h12345, 20'h00007, 20'h10000, 20'h09999, 20'h00100};
  logic [15:0] e4   [8] = '{16'h5535, 16'h1234, 16'hFFF0, 16'h2345, 16'hFFF7, 16'h0000, 16'h9999, 16'hF100};
  logic        o4   [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int lat, busyc, donec, ndone;
    logic [15:0] fv;
    resetn = 1'b0; start_tb = 1'b0; bin_tb = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(if5.busy), 32'd0);
    check("rst_done", 32'(if5.done), 32'd0);
    check("rst_ovf", 32'(if5.overflow), 32'd0);
    check("rst_bcd", 32'(if5.bcd), 32'hFFFFF);
    check("rst_bcd_nb", 32'(ifnb.bcd), 32'h00000);
    check("rst_bcd4", 32'(if4.bcd), 32'hFFFF);
    @(negedge clk) resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      conv(vin[i], lat, busyc, donec);
      check($sformatf("lat_%0d", vin[i]), 32'(lat), 32'd17);
      check($sformatf("busy_%0d", vin[i]), 32'(busyc), 32'd17);
      check($sformatf("donecnt_%0d", vin[i]), 32'(donec), 32'd1);
      check($sformatf("bcd5_%0d", vin[i]), 32'(if5.bcd), 32'(e5[i]));
      check($sformatf("ovf5_%0d", vin[i]), 32'(if5.overflow), 32'd0);
      check($sformatf("bcdnb_%0d", vin[i]), 32'(ifnb.bcd), 32'(e5nb[i]));
      check($sformatf("bcd4_%0d", vin[i]), 32'(if4.bcd), 32'(e4[i]));
      check($sformatf("ovf4_%0d", vin[i]), 32'(if4.overflow), 32'(o4[i]));
    end

    // start held high, bin changing every cycle: accepts at 0, 18, 36.
    ndone = 0;
    for (int c = 0; c < 54; c++) begin
      @(negedge clk);
      bin_tb = 16'((c * 2731 + 17) & 16'hFFFF);
      start_tb = 1'b1;
      @(posedge clk);
      #1;
      if (if5.done) begin
        ndone++;
        check("b2b_spacing", 32'(c % 18), 32'd17);
        fv = 16'(((c - 17) * 2731 + 17) & 16'hFFFF);
        check($sformatf("b2b_bcd_c%0d", c), 32'(if5.bcd), exp_bcd(32'(fv), 5, 1'b1));
        check($sformatf("b2b_bcd4_c%0d", c), 32'(if4.bcd), exp_bcd(32'(fv), 4, 1'b1));
      end
    end
    start_tb = 1'b0;
    check("b2b_done_count", 32'(ndone), 32'd3);

    // Reset eight cycles into a conversion.
    @(negedge clk);
    bin_tb = 16'd4321; start_tb = 1'b1;
    @(posedge clk);
    #1 start_tb = 1'b0;
    repeat (8) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(if5.busy), 32'd0);
    check("mid_rst_done", 32'(if5.done), 32'd0);
    check("mid_rst_bcd", 32'(if5.bcd), 32'hFFFFF);
    check("mid_rst_ovf4", 32'(if4.overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (if5.done) ndone++;
    end
    check("post_rst_no_done", 32'(ndone), 32'd0);
    conv(16'd4321, lat, busyc, donec);
    check("post_rst_lat", 32'(lat), 32'd17);
    check("post_rst_bcd", 32'(if5.bcd), 32'hF4321);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
